// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared constants for the processor datapath register bank:
//                default geometry and clear/run state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package proc_pkg;

   // Default register bank geometry
   localparam int REG_DATA_W = 16;
   localparam int REG_DEPTH  = 8;

   // Register bank controller state encoding
   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_RUN   = 1'b1;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/reg_bank_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_clear_ctrl
//  Description : Post-reset initialisation sequencer. Walks every entry of the
//                register bank writing zero, then enters RUN and raises ready.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_bank_clear_ctrl
   import proc_pkg::*;
#(
   parameter  int DEPTH  = REG_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rst,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              ready
);

   localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH - 1);

   logic              r_state;
   logic              w_state_nxt;
   logic [ADDR_W-1:0] r_index;
   logic [ADDR_W-1:0] w_index_nxt;

   // State register and clear index; reset restarts the clear pass at entry 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_CLEAR;
         r_index <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_index <= w_index_nxt;
      end
   end

   // Next-state: advance through every entry, leave CLEAR after the last one
   always_comb begin
      w_state_nxt = r_state;
      w_index_nxt = r_index;
      if (r_state == ST_CLEAR) begin
         w_index_nxt = r_index + 1'b1;
         if (r_index == c_LAST_IDX) begin
            w_state_nxt = ST_RUN;
         end
      end
   end

   // Outputs: clear write strobe while clearing, ready once running
   always_comb begin
      clr_we   = (r_state == ST_CLEAR);
      clr_addr = r_index;
      ready    = (r_state == ST_RUN);
   end

endmodule : reg_bank_clear_ctrl
`default_nettype wire

// File: rtl/reg_bank_sync.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_sync
//  Description : Synchronous register bank, two registered read ports, one
//                write port with write-to-read bypass, optional hardwired-zero
//                entry 0 and self-clearing initialisation after reset.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_bank_sync
   import proc_pkg::*;
#(
   parameter  int DATA_W   = REG_DATA_W,
   parameter  int DEPTH    = REG_DEPTH,
   parameter  bit ZERO_REG = 1'b0,
   localparam int ADDR_W   = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              chip_enable,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] select1,
   input  logic [ADDR_W-1:0] select2,
   output logic [DATA_W-1:0] source1,
   output logic [DATA_W-1:0] source2,
   output logic              ready
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_source1;
   logic [DATA_W-1:0] r_source2;

   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_ready;
   logic              w_zero_drop;
   logic              w_run_we;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_data;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;

   reg_bank_clear_ctrl #(
      .DEPTH    (DEPTH)
   ) u_clear_ctrl (
      .clk      (clk),
      .rst      (rst),
      .clr_we   (w_clr_we),
      .clr_addr (w_clr_addr),
      .ready    (w_ready)
   );

   // Write port arbitration: the clear pass owns the array until ready
   always_comb begin
      w_zero_drop = ZERO_REG && (waddr == '0);
      w_run_we    = w_ready && chip_enable && we && !w_zero_drop;
      w_mem_we    = w_clr_we || w_run_we;
      w_mem_addr  = w_clr_we ? w_clr_addr : waddr;
      w_mem_data  = w_clr_we ? '0 : wdata;
   end

   // Read data with same-cycle bypass; a dropped zero-entry write reads 0
   always_comb begin
      w_rd1 = r_mem[select1];
      w_rd2 = r_mem[select2];
      if (ZERO_REG && (select1 == '0)) w_rd1 = '0;
      if (ZERO_REG && (select2 == '0)) w_rd2 = '0;
      if (we && (select1 == waddr)) w_rd1 = w_zero_drop ? '0 : wdata;
      if (we && (select2 == waddr)) w_rd2 = w_zero_drop ? '0 : wdata;
   end

   // Storage array; contents are zeroed by the clear pass, not by reset
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_data;
      end
   end

   // Registered read ports: zero while clearing, hold unless enabled and read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_source1 <= '0;
         r_source2 <= '0;
      end else if (w_clr_we) begin
         r_source1 <= '0;
         r_source2 <= '0;
      end else if (chip_enable && re) begin
         r_source1 <= w_rd1;
         r_source2 <= w_rd2;
      end
   end

   assign source1 = r_source1;
   assign source2 = r_source2;
   assign ready   = w_ready;

endmodule : reg_bank_sync
`default_nettype wire

// File: tb/tb_reg_bank_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bank_sync
//  Description : Self-checking bench for reg_bank_sync. Two instances run in
//                lock-step: default geometry (8x16, no zero entry) and a 32x32
//                bank with a hardwired-zero entry 0.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_bank_sync;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [4:0]  waddr = '0;
   logic [4:0]  s1 = '0;
   logic [4:0]  s2 = '0;
   logic [31:0] wdata = '0;

   logic [15:0] a_src1, a_src2;
   logic        a_rdy;
   logic [31:0] b_src1, b_src2;
   logic        b_rdy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   reg_bank_sync u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .chip_enable (ce),
      .we          (we),
      .waddr       (waddr[2:0]),
      .wdata       (wdata[15:0]),
      .re          (re),
      .select1     (s1[2:0]),
      .select2     (s2[2:0]),
      .source1     (a_src1),
      .source2     (a_src2),
      .ready       (a_rdy)
   );

   reg_bank_sync #(
      .DATA_W      (32),
      .DEPTH       (32),
      .ZERO_REG    (1'b1)
   ) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .chip_enable (ce),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .re          (re),
      .select1     (s1),
      .select2     (s2),
      .source1     (b_src1),
      .source2     (b_src2),
      .ready       (b_rdy)
   );

   // Reference model: index 0 = default bank, index 1 = 32x32 zero-entry bank
   int          depth [2] = '{8, 32};
   bit          zreg  [2] = '{1'b0, 1'b1};
   logic [31:0] dmask [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};
   logic [31:0] mem   [2][32];
   int          edges [2];
   logic [31:0] exp1  [2];
   logic [31:0] exp2  [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         edges[k] = 0;
         exp1[k]  = '0;
         exp2[k]  = '0;
         for (int i = 0; i < 32; i++) mem[k][i] = '0;
      end
   endtask

   function automatic logic [31:0] model_read(input int k, input int sel, input int wa,
                                              input logic [31:0] d, input bit drop);
      if (we && sel == wa) return drop ? 32'h0 : d;
      if (zreg[k] && sel == 0) return 32'h0;
      return mem[k][sel];
   endfunction

   // Advance the model by one rising edge using the inputs currently applied
   task automatic model_edge();
      int wa, r1, r2;
      logic [31:0] d;
      bit drop;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            edges[k] = 0;
            exp1[k]  = '0;
            exp2[k]  = '0;
         end else if (edges[k] < depth[k]) begin
            edges[k]++;
         end else if (ce) begin
            wa   = int'(waddr) % depth[k];
            r1   = int'(s1) % depth[k];
            r2   = int'(s2) % depth[k];
            d    = wdata & dmask[k];
            drop = zreg[k] && wa == 0;
            if (re) begin
               exp1[k] = model_read(k, r1, wa, d, drop);
               exp2[k] = model_read(k, r2, wa, d, drop);
            end
            if (we && !drop) mem[k][wa] = d;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, " a.ready"},   {31'h0, a_rdy},  {31'h0, edges[0] >= depth[0]});
      check({tag, " a.source1"}, {16'h0, a_src1}, exp1[0]);
      check({tag, " a.source2"}, {16'h0, a_src2}, exp2[0]);
      check({tag, " b.ready"},   {31'h0, b_rdy},  {31'h0, edges[1] >= depth[1]});
      check({tag, " b.source1"}, b_src1, exp1[1]);
      check({tag, " b.source2"}, b_src2, exp2[1]);
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic drive(input bit ce_i, input bit we_i, input int wa_i, input logic [31:0] wd_i,
                        input bit re_i, input int s1_i, input int s2_i);
      ce    = ce_i;
      we    = we_i;
      waddr = 5'(wa_i);
      wdata = wd_i;
      re    = re_i;
      s1    = 5'(s1_i);
      s2    = 5'(s2_i);
   endtask

   // Asynchronous reset: outputs must drop before any clock edge
   task automatic do_reset(input string tag);
      rst = 1'b1;
      model_reset();
      #1;
      compare_all({tag, " async"});
      cycle({tag, " held"});
      rst = 1'b0;
   endtask

   initial begin
      #2;
      do_reset("por");

      // Initialisation: ready timing for both geometries, stimulus ignored
      drive(1, 1, 3, 32'h5555_5555, 1, 3, 4);
      for (int i = 0; i < 8; i++) cycle("init8");

      // Every default entry reads zero after the clear pass
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 0, 0, 1, i, 7 - i);
         cycle("clr_read");
      end

      // Let the 32-entry bank finish its clear pass
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 24; i++) cycle("init32");

      // Plain write then read
      drive(1, 1, 3, 32'h0000_BEEF, 0, 0, 0);
      cycle("wr3");
      drive(1, 0, 0, 0, 1, 3, 5);
      cycle("rd3_5");

      // Same-cycle bypass on both ports
      drive(1, 1, 6, 32'h0000_1234, 1, 6, 6);
      cycle("bypass6");

      // chip_enable low: no write, outputs hold
      drive(0, 1, 2, 32'h0000_AAAA, 1, 2, 3);
      cycle("ce_off");
      drive(1, 0, 0, 0, 1, 2, 6);
      cycle("rd2_after_ce_off");

      // re low: outputs hold while write still lands
      drive(1, 1, 2, 32'h0000_7777, 0, 2, 2);
      cycle("re_off");
      drive(1, 0, 0, 0, 1, 2, 0);
      cycle("rd2");

      // Hardwired zero entry with bypass read
      drive(1, 1, 0, 32'h0000_FFFF, 1, 0, 0);
      cycle("zero_bypass");
      drive(1, 0, 0, 0, 1, 0, 1);
      cycle("zero_read");

      // Back-to-back writes to one address: last one wins
      drive(1, 1, 9, 32'h1111_1111, 0, 0, 0);
      cycle("b2b_1");
      drive(1, 1, 9, 32'h2222_2222, 0, 0, 0);
      cycle("b2b_2");
      drive(1, 0, 0, 0, 1, 9, 1);
      cycle("b2b_rd");

      // Fill the large bank with its index, then reset mid-run
      for (int i = 0; i < 32; i++) begin
         drive(1, 1, i, i, 0, 0, 0);
         cycle("fill");
      end
      drive(1, 0, 0, 0, 1, 17, 31);
      cycle("fill_rd");
      drive(1, 1, 5, 32'hDEAD_0005, 1, 7, 9);
      do_reset("midrun");
      for (int i = 0; i < 32; i++) cycle("reinit");
      for (int i = 0; i < 32; i++) begin
         drive(1, 0, 0, 0, 1, i, 31 - i);
         cycle("post_reset_rd");
      end

      // Randomised traffic with occasional asynchronous reset
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31),
               $urandom, $urandom_range(0, 3) != 0,
               ($urandom_range(0, 3) == 0) ? int'(waddr) : $urandom_range(0, 31),
               $urandom_range(0, 31));
         if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
         else cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_reg_bank_sync
`default_nettype wire
